// File: rtl/touch_region_scanner_if.sv
// touch_region_scanner_if: sample, region-config and event bundle; drop_cnt exists only with TOUCH_SCAN_DROP_CNT_EN
interface touch_region_scanner_if #(parameter int NREG = 4, parameter int IW = $clog2(NREG));
  logic            sample_valid;
  logic            touch_down;
  logic [9:0]      tor_x;
  logic [8:0]      tor_y;
  logic            cfg_we;
  logic [IW-1:0]   cfg_idx;
  logic [1:0]      cfg_sel;
  logic [9:0]      cfg_data;
  logic            busy;
  logic [NREG-1:0] press;
  logic            release_o;
  logic [NREG-1:0] held;
  logic            hit_valid;
  logic [IW-1:0]   hit_idx;
  logic            hit;
`ifdef TOUCH_SCAN_DROP_CNT_EN
  logic [7:0]      drop_cnt;
  modport master(output sample_valid, touch_down, tor_x, tor_y, cfg_we, cfg_idx, cfg_sel, cfg_data,
                 input busy, press, release_o, held, hit_valid, hit_idx, hit, drop_cnt);
  modport slave(input sample_valid, touch_down, tor_x, tor_y, cfg_we, cfg_idx, cfg_sel, cfg_data,
                output busy, press, release_o, held, hit_valid, hit_idx, hit, drop_cnt);
`else
  modport master(output sample_valid, touch_down, tor_x, tor_y, cfg_we, cfg_idx, cfg_sel, cfg_data,
                 input busy, press, release_o, held, hit_valid, hit_idx, hit);
  modport slave(input sample_valid, touch_down, tor_x, tor_y, cfg_we, cfg_idx, cfg_sel, cfg_data,
                output busy, press, release_o, held, hit_valid, hit_idx, hit);
`endif
endinterface

// File: rtl/touch_region_scanner.sv
// touch_region_scanner: one shared rectangle comparator scans NREG regions per sample, then debounces; TOUCH_SCAN_DROP_CNT_EN adds drop_cnt
module touch_region_scanner #(
  parameter int NREG = 4,
  parameter int HOLD = 3,
  parameter int RELEASE = 2,
  localparam int IW = $clog2(NREG)
) (
  input logic clk,
  input logic reset,
  touch_region_scanner_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DECIDE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, win_q, win_d, cand_q, cand_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic td_q, td_d, found_q, found_d, cand_v_q, cand_v_d;
  logic [9:0] x1_q [NREG], x1_d [NREG], x2_q [NREG], x2_d [NREG];
  logic [8:0] y1_q [NREG], y1_d [NREG], y2_q [NREG], y2_d [NREG];
  logic [3:0] hcnt_q, hcnt_d, mcnt_q, mcnt_d;
  logic [NREG-1:0] held_q, held_d, press_c, onehot;
  logic rel_c, match, hit_now, decide;
  assign match = x1_q[idx_q] <= x_q && x_q <= x2_q[idx_q] && y1_q[idx_q] <= y_q && y_q <= y2_q[idx_q];
  assign decide = state_q == DECIDE;
  assign hit_now = found_q & td_q;
  assign onehot = NREG'(1) << win_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    x_d = x_q;
    y_d = y_q;
    td_d = td_q;
    found_d = found_q;
    win_d = win_q;
    if (state_q == IDLE && bus.sample_valid) begin
      state_d = SCAN;
      idx_d = '0;
      x_d = bus.tor_x;
      y_d = bus.tor_y;
      td_d = bus.touch_down;
      found_d = 1'b0;
      win_d = '0;
    end else if (state_q == SCAN) begin
      found_d = found_q | match;
      win_d = (!found_q && match) ? idx_q : win_q;
      idx_d = idx_q + 1'b1;
      state_d = (idx_q == IW'(NREG - 1)) ? DECIDE : SCAN;
    end else if (decide) begin
      state_d = IDLE;
    end
  end
  always_comb begin
    x1_d = x1_q;
    x2_d = x2_q;
    y1_d = y1_q;
    y2_d = y2_q;
    if (bus.cfg_we && bus.cfg_sel == 2'd0) x1_d[bus.cfg_idx] = bus.cfg_data;
    if (bus.cfg_we && bus.cfg_sel == 2'd1) x2_d[bus.cfg_idx] = bus.cfg_data;
    if (bus.cfg_we && bus.cfg_sel == 2'd2) y1_d[bus.cfg_idx] = bus.cfg_data[8:0];
    if (bus.cfg_we && bus.cfg_sel == 2'd3) y2_d[bus.cfg_idx] = bus.cfg_data[8:0];
  end
  // Debounce: a new candidate restarts the hit count and drops any held region
  always_comb begin
    cand_d = cand_q;
    cand_v_d = cand_v_q;
    hcnt_d = hcnt_q;
    mcnt_d = mcnt_q;
    held_d = held_q;
    press_c = '0;
    rel_c = 1'b0;
    if (decide && hit_now && cand_v_q && cand_q == win_q) begin
      hcnt_d = (hcnt_q == 4'(HOLD)) ? hcnt_q : hcnt_q + 4'd1;
      mcnt_d = '0;
      if (hcnt_d == 4'(HOLD) && held_q == '0) begin
        held_d = onehot;
        press_c = onehot;
      end
    end else if (decide && hit_now) begin
      cand_d = win_q;
      cand_v_d = 1'b1;
      hcnt_d = 4'd1;
      mcnt_d = '0;
      rel_c = held_q != '0;
      held_d = (HOLD == 1) ? onehot : '0;
      press_c = (HOLD == 1) ? onehot : '0;
    end else if (decide) begin
      hcnt_d = '0;
      mcnt_d = (mcnt_q == 4'(RELEASE)) ? mcnt_q : mcnt_q + 4'd1;
      if (mcnt_d == 4'(RELEASE)) begin
        cand_v_d = 1'b0;
        rel_c = held_q != '0;
        held_d = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      win_q <= '0;
      cand_q <= '0;
      cand_v_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      td_q <= 1'b0;
      found_q <= 1'b0;
      hcnt_q <= '0;
      mcnt_q <= '0;
      held_q <= '0;
      for (int r = 0; r < NREG; r++) begin
        x1_q[r] <= (r == 0) ? 10'd184 : 10'd1023;
        x2_q[r] <= (r == 0) ? 10'd326 : 10'd0;
        y1_q[r] <= (r == 0) ? 9'd11 : 9'd511;
        y2_q[r] <= (r == 0) ? 9'd109 : 9'd0;
      end
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      win_q <= win_d;
      cand_q <= cand_d;
      cand_v_q <= cand_v_d;
      x_q <= x_d;
      y_q <= y_d;
      td_q <= td_d;
      found_q <= found_d;
      hcnt_q <= hcnt_d;
      mcnt_q <= mcnt_d;
      held_q <= held_d;
      x1_q <= x1_d;
      x2_q <= x2_d;
      y1_q <= y1_d;
      y2_q <= y2_d;
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.hit_valid = decide;
  assign bus.hit = decide & hit_now;
  assign bus.hit_idx = (decide && hit_now) ? win_q : '0;
  assign bus.press = press_c;
  assign bus.release_o = rel_c;
  assign bus.held = held_q;
`ifdef TOUCH_SCAN_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;
  assign drop_d = (bus.busy && bus.sample_valid && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
  always_ff @(posedge clk) begin
    if (!reset) drop_q <= '0;
    else drop_q <= drop_d;
  end
  assign bus.drop_cnt = drop_q;
`endif
endmodule

// File: tb/tb_touch_region_scanner.sv
// tb_touch_region_scanner: directed vectors with hand-computed expectations for touch_region_scanner
module tb_touch_region_scanner;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  touch_region_scanner_if #(.NREG(4)) bus();
  touch_region_scanner #(.NREG(4), .HOLD(3), .RELEASE(2)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cfg(input logic [1:0] idx, input logic [1:0] sel, input logic [9:0] data);
    bus.cfg_we = 1'b1;
    bus.cfg_idx = idx;
    bus.cfg_sel = sel;
    bus.cfg_data = data;
    tick;
    bus.cfg_we = 1'b0;
  endtask
  task automatic scan(input string tag, input logic [9:0] x, input logic [8:0] y, input logic td,
                      input logic eh, input logic [1:0] eix, input logic [3:0] epr, input logic erl,
                      input logic [3:0] eheld);
    int lat;
    bus.sample_valid = 1'b1;
    bus.tor_x = x;
    bus.tor_y = y;
    bus.touch_down = td;
    tick;
    bus.sample_valid = 1'b0;
    lat = 1;
    while (!bus.hit_valid && lat < 20) begin
      tick;
      lat++;
    end
    chk({tag, "_lat"}, lat, 5);
    chk({tag, "_hit"}, bus.hit, eh);
    chk({tag, "_idx"}, bus.hit_idx, eix);
    chk({tag, "_press"}, bus.press, epr);
    chk({tag, "_rel"}, bus.release_o, erl);
    tick;
    chk({tag, "_held"}, bus.held, eheld);
  endtask
  initial begin
    int hv_seen;
    bus.sample_valid = 1'b0;
    bus.touch_down = 1'b0;
    bus.tor_x = '0;
    bus.tor_y = '0;
    bus.cfg_we = 1'b0;
    bus.cfg_idx = '0;
    bus.cfg_sel = '0;
    bus.cfg_data = '0;
    tick;
    tick;
    chk("rst_busy", bus.busy, 0);
    chk("rst_hv", bus.hit_valid, 0);
    chk("rst_held", bus.held, 0);
    chk("rst_press", bus.press, 0);
    chk("rst_rel", bus.release_o, 0);
    reset = 1'b1;
    tick;
    scan("s1", 200, 50, 1, 1, 0, 4'b0000, 0, 4'b0000);
    repeat (2) tick;
    scan("s2", 200, 50, 1, 1, 0, 4'b0000, 0, 4'b0000);
    repeat (2) tick;
    scan("s3", 200, 50, 1, 1, 0, 4'b0001, 0, 4'b0001);
    scan("b_lo", 184, 11, 1, 1, 0, 4'b0000, 0, 4'b0001);
    scan("b_hi", 326, 109, 1, 1, 0, 4'b0000, 0, 4'b0001);
    scan("b_xl", 183, 50, 1, 0, 0, 4'b0000, 0, 4'b0001);
    scan("b_xh", 327, 50, 1, 0, 0, 4'b0000, 1, 4'b0000);
    scan("b_yl", 200, 10, 1, 0, 0, 4'b0000, 0, 4'b0000);
    scan("b_yh", 200, 110, 1, 0, 0, 4'b0000, 0, 4'b0000);
    cfg(1, 0, 0);
    cfg(1, 1, 100);
    cfg(1, 2, 0);
    cfg(1, 3, 100);
    cfg(0, 0, 50);
    cfg(0, 1, 300);
    cfg(0, 2, 0);
    cfg(0, 3, 100);
    scan("prio", 90, 50, 1, 1, 0, 4'b0000, 0, 4'b0000);
    cfg(0, 0, 1023);
    scan("dis0", 90, 50, 1, 1, 1, 4'b0000, 0, 4'b0000);
    cfg(0, 0, 184);
    cfg(0, 1, 326);
    cfg(0, 2, 11);
    cfg(0, 3, 109);
    scan("h1", 200, 50, 1, 1, 0, 4'b0000, 0, 4'b0000);
    scan("h2", 200, 50, 1, 1, 0, 4'b0000, 0, 4'b0000);
    scan("h3", 200, 50, 1, 1, 0, 4'b0001, 0, 4'b0001);
    scan("up1", 200, 50, 0, 0, 0, 4'b0000, 0, 4'b0001);
    scan("up2", 200, 50, 0, 0, 0, 4'b0000, 1, 4'b0000);
    scan("k1", 200, 50, 1, 1, 0, 4'b0000, 0, 4'b0000);
    scan("k2", 200, 50, 1, 1, 0, 4'b0000, 0, 4'b0000);
    scan("k3", 200, 50, 1, 1, 0, 4'b0001, 0, 4'b0001);
    scan("miss1", 200, 50, 0, 0, 0, 4'b0000, 0, 4'b0001);
    scan("rehit", 200, 50, 1, 1, 0, 4'b0000, 0, 4'b0001);
    bus.sample_valid = 1'b1;
    bus.tor_x = 200;
    bus.tor_y = 50;
    bus.touch_down = 1'b1;
    chk("bz_t0", bus.busy, 0);
    tick;
    bus.sample_valid = 1'b0;
    chk("bz_t1", bus.busy, 1);
    tick;
    bus.sample_valid = 1'b1;
    bus.tor_x = 500;
    bus.tor_y = 300;
    bus.touch_down = 1'b0;
    chk("bz_t2", bus.busy, 1);
    chk("bz_hv2", bus.hit_valid, 0);
    tick;
    bus.sample_valid = 1'b0;
    for (int c = 3; c <= 6; c++) begin
      chk($sformatf("bz_t%0d", c), bus.busy, (c <= 5) ? 1 : 0);
      chk($sformatf("bz_hv%0d", c), bus.hit_valid, (c == 5) ? 1 : 0);
      if (c == 5) begin
        chk("bz_hit", bus.hit, 1);
        chk("bz_idx", bus.hit_idx, 0);
      end
      tick;
    end
`ifdef TOUCH_SCAN_DROP_CNT_EN
    chk("drop_cnt", bus.drop_cnt, 1);
`endif
    cfg(0, 0, 0);
    bus.sample_valid = 1'b1;
    bus.tor_x = 50;
    bus.tor_y = 50;
    bus.touch_down = 1'b1;
    tick;
    bus.sample_valid = 1'b0;
    tick;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    chk("ar_busy", bus.busy, 0);
    chk("ar_hv", bus.hit_valid, 0);
    chk("ar_held", bus.held, 0);
    chk("ar_press", bus.press, 0);
    chk("ar_rel", bus.release_o, 0);
    chk("ar_hit", bus.hit, 0);
`ifdef TOUCH_SCAN_DROP_CNT_EN
    chk("ar_drop", bus.drop_cnt, 0);
`endif
    hv_seen = 0;
    for (int c = 0; c < 8; c++) begin
      hv_seen += int'(bus.hit_valid);
      tick;
    end
    chk("ar_nohv", hv_seen, 0);
    scan("def0", 200, 50, 1, 1, 0, 4'b0000, 0, 4'b0000);
    scan("def1", 50, 50, 1, 0, 0, 4'b0000, 0, 4'b0000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
